fp_standardizer_pipe: RTL and testbench
=======================================

// Module: fp_standardizer_pipe
// PURPOSE
//  Pipelined, parametrised normalise-and-round stage for the FP adder/subtractor datapath.
//  Takes the raw sign/exponent/extended mantissa from the add/sub core.
//  Returns an IEEE-754-style packed result (no subnormals) with a selectable rounding mode and exception flags.
//  Three register stages with valid/ready handshake; full throughput of one result per clock.
// PARAMETERS
//  EXP_W  8   exponent field width; bias = 2**(EXP_W-1)-1
//  MAN_W  23  stored fraction width; extended mantissa MW = MAN_W+5
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      input beat present
//  in_ready    out  1      block accepts beat this cycle
//  sign_in     in   1      result sign
//  exp_in      in   EXP_W  biased exponent before normalisation
//  mantis_in   in   MW     [MW-1]=carry, [MW-2]=hidden, [MW-3:3]=fraction, [2]=guard, [1]=round, [0]=sticky
//  sticky_in   in   1      extra sticky from alignment shift; ORed into bit 0
//  rm_in       in   2      rounding mode: 0=RNE 1=RTZ 2=RUP(+inf) 3=RDN(-inf)
//  out_valid   out  1      result beat present
//  out_ready   in   1      downstream accepts
//  sign_out    out  1      result sign (0 for flushed zero only if input zero; otherwise kept)
//  exp_out     out  EXP_W  biased result exponent
//  mantis_out  out  MAN_W  stored fraction
//  flags_out   out  3      {overflow, underflow, inexact}
// BEHAVIOUR
//  Reset: all stage valids 0; out_valid=0, sign_out=0, exp_out=0, mantis_out=0, flags_out=0; in_ready=1.
//  Reset mid-operation discards all in-flight beats; no output beat after release until a new input.
//  Handshake: transfer when valid&&ready. Stage k advances if stage k+1 empty or advancing.
//  in_ready = !v1 || stage1 advancing. Output data held stable while out_valid&&!out_ready.
//  Latency exactly 3 clocks from input transfer to out_valid with no stall; sidebands travel with the beat.
//  S1 (detect): zero = (mantis_in==0 && !sticky_in); lzc = leading zeros of mantis_in[MW-2:0].
//    Register sign, exp, mantissa, rm, zero, lzc.
//  S2 (normalise), signed exponent width EXP_W+2:
//    carry set   -> mantissa >>1, bit 0 = old[1]|old[0], e = exp+1.
//    else        -> mantissa <<lzc, e = exp-lzc.
//    e <= 0      -> underflow: result +/-0, flags {0,1,1}.
//    zero        -> exp 0, mantissa 0, flags 0, sign kept.
//  S3 (round): lsb=fraction[0], g=guard, s=round|sticky.
//    Increment: RNE g&(s|lsb); RTZ 0; RUP !sign&(g|s); RDN sign&(g|s).
//    inexact = g|s.
//    Fraction carry-out on increment -> fraction 0, e+1.
//    e >= 2**EXP_W-1 after rounding -> overflow, inexact=1.
//      Result inf (exp all 1s, frac 0) for RNE, RUP&+, RDN&-; else max finite (exp 2**EXP_W-2, frac all 1s).
//  Flags are mutually consistent: overflow and underflow never both 1.
//  Simultaneous out fire and in fire on a full pipe: every stage shifts, no bubble, no loss.
// STRUCTURE
//  Shared package fp_pkg:
//    RM_RNE/RM_RTZ/RM_RUP/RM_RDN constants, flag bit indices, MW derivation, bias function.
//  One natural sub-module: fp_lzc (parametrised leading-zero counter, width MW-1), instanced in S1.
//  Normalise and round stay inline as pipeline stages.
// TESTING (EXP_W=8, MAN_W=23, MW=28, RNE unless stated)
//  exp 127, mantis 28'h4000000 -> exp 127, mant 0, flags 0, out_valid 3 clocks after accept.
//  exp 127, mantis 28'h8000000 (carry) -> exp 128, mant 0; exp 127, mantis 28'h0000008 -> exp 104, mant 0.
//  Ties, exp 127:
//    28'h4000004 -> mant 0, flags 3'b001.
//    28'h400000C -> mant 2, flags 3'b001.
//    Same with RTZ -> mant 1.
//  exp 254, mantis 28'h7FFFFFC, RNE -> exp 255, mant 0, flags 3'b101.
//    Same with RTZ -> exp 254, mant 23'h7FFFFF.
//  exp 3, mantis 28'h0000008 -> exp 0, mant 0, flags 3'b011; mantis 0 -> all-zero result, flags 0.
//  Backpressure/reset:
//    Stream 6 beats, out_ready low 5 clocks -> in_ready low after 3 accepted, outputs stable, order preserved.
//    Assert rst mid-stream -> out_valid 0 immediately, no stale beat after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point normalise/round datapath.
//   rm_e      : rounding-mode encoding carried alongside each beat
//   FLAG_*    : bit positions inside the 3-bit {overflow, underflow, inexact} flag word
//   mw_of     : extended-mantissa width (carry, hidden, fraction, guard, round, sticky)
//   bias_of   : exponent bias for a given exponent field width
package fp_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,  // round to nearest, ties to even
    RM_RTZ = 2'd1,  // round toward zero
    RM_RUP = 2'd2,  // round toward +inf
    RM_RDN = 2'd3   // round toward -inf
  } rm_e;

  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  function automatic int mw_of(input int man_w);
    return man_w + 5;
  endfunction

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter.
//   i_data  : vector to scan, MSB first
//   o_count : number of zeros above the most significant 1 (W when i_data is all zero)
module fp_lzc #(
  parameter int W  = 27,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_data,
  output logic [CW-1:0] o_count
);

  // Scan LSB to MSB so the highest set bit is the last one to write the count.
  always_comb begin
    o_count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) o_count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_standardizer_pipe.sv
// Three-stage normalise-and-round pipeline for the FP add/sub datapath.
// Produces a packed sign/exponent/fraction result (no subnormals) with
// {overflow, underflow, inexact} flags.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : input beat handshake
//   sign_in, exp_in      : sign and biased exponent before normalisation
//   mantis_in            : {carry, hidden, fraction, guard, round, sticky}
//   sticky_in            : extra alignment sticky, ORed into mantissa bit 0
//   rm_in                : rounding mode (rm_e encoding)
//   out_valid / out_ready: output beat handshake
//   sign_out, exp_out, mantis_out, flags_out : packed result and flags
//
// Handshake: a beat moves on a clock edge when valid && ready at that edge.
// A stage loads when it is empty or its downstream stage is loading, so a
// full pipe with out_ready high shifts every stage each cycle without a
// bubble. Output registers hold while out_valid && !out_ready.
module fp_standardizer_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sign_in,
  input  logic [EXP_W-1:0]   exp_in,
  input  logic [MAN_W+4:0]   mantis_in,
  input  logic               sticky_in,
  input  logic [1:0]         rm_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sign_out,
  output logic [EXP_W-1:0]   exp_out,
  output logic [MAN_W-1:0]   mantis_out,
  output logic [2:0]         flags_out
);

  localparam int MW  = mw_of(MAN_W);
  localparam int LZW = $clog2(MW);
  localparam int EW  = EXP_W + 2;  // signed exponent with headroom both ways
  localparam logic signed [EW-1:0] E_MAX    = EW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]     EXP_INF  = '1;
  localparam logic [EXP_W-1:0]     EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

  // ---------------- stage enables ----------------
  logic r_v1, r_v2, r_v3;
  logic w_en1, w_en2, w_en3;

  assign w_en3    = !r_v3 || out_ready;
  assign w_en2    = !r_v2 || w_en3;
  assign w_en1    = !r_v1 || w_en2;
  assign in_ready = w_en1;

  // ---------------- S1: detect ----------------
  logic [MW-1:0]  w_man_in;
  logic [LZW-1:0] w_lzc;

  logic           r_s1_sign, r_s1_zero;
  logic [EXP_W-1:0] r_s1_exp;
  logic [MW-1:0]  r_s1_man;
  rm_e            r_s1_rm;
  logic [LZW-1:0] r_s1_lzc;

  assign w_man_in = mantis_in | {{(MW-1){1'b0}}, sticky_in};

  fp_lzc #(.W(MW - 1), .CW(LZW)) u_lzc (
    .i_data  (w_man_in[MW-2:0]),
    .o_count (w_lzc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_zero <= 1'b0;
      r_s1_exp  <= '0;
      r_s1_man  <= '0;
      r_s1_rm   <= RM_RNE;
      r_s1_lzc  <= '0;
    end else if (w_en1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_s1_sign <= sign_in;
        r_s1_zero <= (w_man_in == '0);
        r_s1_exp  <= exp_in;
        r_s1_man  <= w_man_in;
        r_s1_rm   <= rm_e'(rm_in);
        r_s1_lzc  <= w_lzc;
      end
    end
  end

  // ---------------- S2: normalise ----------------
  logic signed [EW-1:0] w_exp_ext, w_lzc_ext, w_e_norm;
  logic [MW-1:0]        w_man_norm;

  assign w_exp_ext = signed'({2'b00, r_s1_exp});
  assign w_lzc_ext = signed'({{(EW-LZW){1'b0}}, r_s1_lzc});

  always_comb begin
    w_e_norm   = w_exp_ext;
    w_man_norm = r_s1_man;
    if (r_s1_man[MW-1]) begin
      // Carry out of the adder: shift right once, folding the dropped bit into sticky.
      w_man_norm = {1'b0, r_s1_man[MW-1:2], r_s1_man[1] | r_s1_man[0]};
      w_e_norm   = w_exp_ext + EW'(1);
    end else begin
      w_man_norm = r_s1_man << r_s1_lzc;
      w_e_norm   = w_exp_ext - w_lzc_ext;
    end
  end

  logic                 r_s2_sign, r_s2_zero, r_s2_unf;
  rm_e                  r_s2_rm;
  logic [MW-1:0]        r_s2_man;
  logic signed [EW-1:0] r_s2_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2      <= 1'b0;
      r_s2_sign <= 1'b0;
      r_s2_zero <= 1'b0;
      r_s2_unf  <= 1'b0;
      r_s2_rm   <= RM_RNE;
      r_s2_man  <= '0;
      r_s2_e    <= '0;
    end else if (w_en2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s2_sign <= r_s1_sign;
        r_s2_zero <= r_s1_zero;
        r_s2_unf  <= !r_s1_zero && (w_e_norm <= 0);
        r_s2_rm   <= r_s1_rm;
        r_s2_man  <= w_man_norm;
        r_s2_e    <= w_e_norm;
      end
    end
  end

  // ---------------- S3: round ----------------
  logic [MAN_W-1:0]     w_frac;
  logic                 w_lsb, w_g, w_s, w_inc, w_to_inf, w_ovf;
  logic [MAN_W:0]       w_frac_sum;
  logic signed [EW-1:0] w_e_rnd;

  assign w_frac = r_s2_man[MW-3:3];
  assign w_lsb  = r_s2_man[3];
  assign w_g    = r_s2_man[2];
  assign w_s    = r_s2_man[1] | r_s2_man[0];

  always_comb begin
    w_inc = 1'b0;
    unique case (r_s2_rm)
      RM_RNE: w_inc = w_g & (w_s | w_lsb);
      RM_RTZ: w_inc = 1'b0;
      RM_RUP: w_inc = !r_s2_sign & (w_g | w_s);
      RM_RDN: w_inc = r_s2_sign & (w_g | w_s);
      default: w_inc = 1'b0;
    endcase
  end

  assign w_frac_sum = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_inc};
  // A fraction carry-out leaves the fraction bits at zero and bumps the exponent.
  assign w_e_rnd  = r_s2_e + signed'({{(EW-1){1'b0}}, w_frac_sum[MAN_W]});
  assign w_ovf    = (w_e_rnd >= E_MAX);
  assign w_to_inf = (r_s2_rm == RM_RNE) || (r_s2_rm == RM_RUP && !r_s2_sign) ||
                    (r_s2_rm == RM_RDN && r_s2_sign);

  logic [EXP_W-1:0] w_exp3;
  logic [MAN_W-1:0] w_frac3;
  logic [2:0]       w_flags3;

  always_comb begin
    w_exp3   = w_e_rnd[EXP_W-1:0];
    w_frac3  = w_frac_sum[MAN_W-1:0];
    w_flags3 = '0;
    if (r_s2_zero) begin
      w_exp3  = '0;
      w_frac3 = '0;
    end else if (r_s2_unf) begin
      w_exp3             = '0;
      w_frac3            = '0;
      w_flags3[FLAG_UNF] = 1'b1;
      w_flags3[FLAG_INX] = 1'b1;
    end else if (w_ovf) begin
      w_exp3             = w_to_inf ? EXP_INF : EXP_MAXF;
      w_frac3            = w_to_inf ? '0 : '1;
      w_flags3[FLAG_OVF] = 1'b1;
      w_flags3[FLAG_INX] = 1'b1;
    end else begin
      w_flags3[FLAG_INX] = w_g | w_s;
    end
  end

  logic             r_sign3;
  logic [EXP_W-1:0] r_exp3;
  logic [MAN_W-1:0] r_frac3;
  logic [2:0]       r_flags3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3     <= 1'b0;
      r_sign3  <= 1'b0;
      r_exp3   <= '0;
      r_frac3  <= '0;
      r_flags3 <= '0;
    end else if (w_en3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_sign3  <= r_s2_sign;
        r_exp3   <= w_exp3;
        r_frac3  <= w_frac3;
        r_flags3 <= w_flags3;
      end
    end
  end

  assign out_valid  = r_v3;
  assign sign_out   = r_sign3;
  assign exp_out    = r_exp3;
  assign mantis_out = r_frac3;
  assign flags_out  = r_flags3;

endmodule

// File: tb/tb_fp_standardizer_pipe.sv
module tb_fp_standardizer_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, sign_in, sticky_in;
  logic [7:0]  exp_in;
  logic [27:0] mantis_in;
  logic [1:0]  rm_in;
  logic        out_valid, sign_out;
  logic        out_ready;
  logic [7:0]  exp_out;
  logic [22:0] mantis_out;
  logic [2:0]  flags_out;

  // out_ready: 0 = held low, 1 = held high, 2 = random per cycle
  logic [1:0]  ready_mode;
  logic        rnd_bit;
  assign out_ready = (ready_mode == 2'd1) || ((ready_mode == 2'd2) && rnd_bit);

  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clk);
      #1 rnd_bit = ($urandom_range(0, 2) != 0);
    end
  end

  fp_standardizer_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign_in    (sign_in),
    .exp_in     (exp_in),
    .mantis_in  (mantis_in),
    .sticky_in  (sticky_in),
    .rm_in      (rm_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sign_out   (sign_out),
    .exp_out    (exp_out),
    .mantis_out (mantis_out),
    .flags_out  (flags_out)
  );

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: locate the leading one, take 23 fraction bits below it, the next
  // bit as guard and everything further down as sticky, then round by value.
  function automatic logic [34:0] model(input logic sg, input logic [7:0] ex,
                                        input logic [27:0] mn, input logic st,
                                        input logic [1:0] rm);
    longint m, frac, mask;
    int p, e;
    logic g, s, inc, to_inf;
    m = longint'(mn) | longint'(st);
    if (m == 0) return {sg, 8'd0, 23'd0, 3'b000};
    p = 27;
    while (((m >> p) & 1) == 0) p--;
    e = int'(ex) + p - 26;
    if (e <= 0) return {sg, 8'd0, 23'd0, 3'b011};
    mask = (longint'(1) << 23) - 1;
    if (p >= 24) begin
      frac = (m >> (p - 23)) & mask;
      g    = ((m >> (p - 24)) & 1) != 0;
      s    = (m & ((longint'(1) << (p - 24)) - 1)) != 0;
    end else begin
      frac = (m << (23 - p)) & mask;
      g    = 1'b0;
      s    = 1'b0;
    end
    case (rm)
      2'd0:    inc = g && (s || frac[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = !sg && (g || s);
      default: inc = sg && (g || s);
    endcase
    frac = frac + longint'(inc);
    if (frac == (longint'(1) << 23)) begin
      frac = 0;
      e    = e + 1;
    end
    if (e >= 255) begin
      to_inf = (rm == 2'd0) || (rm == 2'd2 && !sg) || (rm == 2'd3 && sg);
      return to_inf ? {sg, 8'hFF, 23'd0, 3'b101} : {sg, 8'hFE, 23'h7FFFFF, 3'b101};
    end
    return {sg, e[7:0], frac[22:0], 2'b00, (g || s)};
  endfunction

  // Monitor: pop and compare on every output transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h, required no beat",
                 {sign_out, exp_out, mantis_out, flags_out});
      end else begin
        check("result", {sign_out, exp_out, mantis_out, flags_out}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic sg, input logic [7:0] ex, input logic [27:0] mn,
                      input logic st, input logic [1:0] rm);
    bit done = 0;
    sign_in = sg; exp_in = ex; mantis_in = mn; sticky_in = st; rm_in = rm;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(sg, ex, mn, st, rm));
        n_acc++;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 35'd0, 35'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 35'(exp_q.size()), 35'd0);
  endtask

  function automatic logic [27:0] rand_man();
    logic [27:0] r;
    r = 28'($urandom);
    case ($urandom_range(0, 3))
      0:       return {1'b1, r[26:0]};
      1:       return {2'b01, r[25:0]};
      2:       return r >> $urandom_range(0, 27);
      default: return {2'b01, 23'h7FFFFF, r[2:0]};
    endcase
  endfunction

  function automatic logic [7:0] rand_exp();
    logic [7:0] edges [7] = '{8'd0, 8'd1, 8'd3, 8'd27, 8'd253, 8'd254, 8'd255};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 6)];
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic send_rand();
    send(1'($urandom), rand_exp(), rand_man(), ($urandom_range(0, 3) == 0), 2'($urandom));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, stale;
    rst = 1'b1; in_valid = 1'b0; sign_in = 1'b0; exp_in = '0; mantis_in = '0;
    sticky_in = 1'b0; rm_in = '0; ready_mode = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 35'(out_valid), 35'd0);
    check("rst_in_ready", 35'(in_ready), 35'd1);
    check("rst_outputs", {sign_out, exp_out, mantis_out, flags_out}, 35'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency: accepting edge counts as the first of the three register edges.
    send(1'b0, 8'd127, 28'h4000000, 1'b0, 2'd0);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    check("latency", 35'(lat), 35'd3);
    @(posedge clk); #1;

    // Directed cases
    send(1'b0, 8'd127, 28'h8000000, 1'b0, 2'd0);
    send(1'b0, 8'd127, 28'h0000008, 1'b0, 2'd0);
    send(1'b0, 8'd127, 28'h4000004, 1'b0, 2'd0);
    send(1'b0, 8'd127, 28'h400000C, 1'b0, 2'd0);
    send(1'b0, 8'd127, 28'h400000C, 1'b0, 2'd1);
    send(1'b0, 8'd254, 28'h7FFFFFC, 1'b0, 2'd0);
    send(1'b0, 8'd254, 28'h7FFFFFC, 1'b0, 2'd1);
    send(1'b1, 8'd254, 28'h7FFFFFC, 1'b0, 2'd2);
    send(1'b1, 8'd254, 28'h7FFFFFC, 1'b0, 2'd3);
    send(1'b0, 8'd3,   28'h0000008, 1'b0, 2'd0);
    send(1'b0, 8'd3,   28'h0000000, 1'b0, 2'd0);
    send(1'b1, 8'd100, 28'h4000001, 1'b0, 2'd3);
    send(1'b0, 8'd100, 28'h4000000, 1'b1, 2'd2);
    wait_drain();

    // Backpressure: six beats against a stalled sink for five clocks.
    ready_mode = 2'd0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand();
      end
      begin
        logic [34:0] held;
        bit have = 0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (out_valid) begin
            if (!have) begin
              held = {sign_out, exp_out, mantis_out, flags_out};
              have = 1;
            end else begin
              check("bp_stable", {sign_out, exp_out, mantis_out, flags_out}, held);
            end
          end
          if (c == 4) begin
            check("bp_accepted", 35'(n_acc), 35'd3);
            check("bp_in_ready", 35'(in_ready), 35'd0);
            check("bp_out_valid", 35'(out_valid), 35'd1);
          end
          @(posedge clk);
        end
        #1 ready_mode = 2'd1;
      end
    join
    wait_drain();

    // Reset mid-stream: beats in flight must vanish.
    send_rand();
    send_rand();
    send_rand();
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 35'(out_valid), 35'd0);
    check("rst_mid_in_ready", 35'(in_ready), 35'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
      @(posedge clk);
    end
    #1;
    check("no_stale_beat", 35'(stale), 35'd0);

    // Random traffic with random sink stalls.
    ready_mode = 2'd2;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send_rand();
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
